// File: rtl/adc_regs_pkg.sv
// Shared constants for the ADC sample register block: register offsets,
// STATUS field positions, AXI response codes and channel limits.
package adc_regs_pkg;

   localparam int unsigned MAX_CH = 16;

   localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
   localparam logic [31:0] ADDR_INFO   = 32'h0000_0008;
   localparam logic [31:0] ADDR_IRQ_EN = 32'h0000_000C;
   localparam logic [31:0] ADDR_DATA0  = 32'h0000_0010;

   localparam int unsigned STATUS_NEW_LSB = 0;
   localparam int unsigned STATUS_OVR_LSB = 16;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
   typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

   function automatic logic [31:0] data_addr(input int unsigned n);
      return ADDR_DATA0 + (32'(n) << 2);
   endfunction

endpackage

// File: rtl/adc_axil_if.sv
// AXI4-Lite slave handshake: one outstanding write and one outstanding read,
// presented to the register bank as single-cycle access strobes.
module adc_axil_if
   import adc_regs_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [3:0]        wr_strb,
   input  logic              wr_err,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   input  logic              rd_err
);

   wr_state_t wr_state;
   rd_state_t rd_state;
   logic      aw_rdy;
   logic      ar_rdy;

   // Write channel: READY goes high for one cycle once address and data are both offered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state <= WR_IDLE;
         aw_rdy   <= 1'b0;
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (aw_rdy) begin
                  aw_rdy <= 1'b0;
                  if (awvalid && wvalid) begin
                     bvalid   <= 1'b1;
                     bresp    <= wr_err ? RESP_SLVERR : RESP_OKAY;
                     wr_state <= WR_RESP;
                  end
               end else if (awvalid && wvalid) begin
                  aw_rdy <= 1'b1;
               end
            end
            WR_RESP: begin
               if (bready) begin
                  bvalid   <= 1'b0;
                  wr_state <= WR_IDLE;
               end
            end
            default: begin
               aw_rdy   <= 1'b0;
               bvalid   <= 1'b0;
               wr_state <= WR_IDLE;
            end
         endcase
      end
   end

   // Read channel: data and response are captured on the acceptance edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         ar_rdy   <= 1'b0;
         rvalid   <= 1'b0;
         rresp    <= RESP_OKAY;
         rdata    <= 32'd0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (ar_rdy) begin
                  ar_rdy <= 1'b0;
                  if (arvalid) begin
                     rvalid   <= 1'b1;
                     rdata    <= rd_data;
                     rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                     rd_state <= RD_DATA;
                  end
               end else if (arvalid) begin
                  ar_rdy <= 1'b1;
               end
            end
            RD_DATA: begin
               if (rready) begin
                  rvalid   <= 1'b0;
                  rd_state <= RD_IDLE;
               end
            end
            default: begin
               ar_rdy   <= 1'b0;
               rvalid   <= 1'b0;
               rd_state <= RD_IDLE;
            end
         endcase
      end
   end

   assign awready = aw_rdy;
   assign wready  = aw_rdy;
   assign arready = ar_rdy;
   assign wr_en   = aw_rdy & awvalid & wvalid;
   assign wr_addr = awaddr;
   assign wr_data = wdata;
   assign wr_strb = wstrb;
   assign rd_en   = ar_rdy & arvalid;
   assign rd_addr = araddr;

endmodule

// File: rtl/adc_axil_regs_mc.sv
// Multi-channel ADC sample registers behind an AXI4-Lite slave.
// Define ADC_REGS_IRQ_EN to add the IRQ_EN register and the irq output.
module adc_axil_regs_mc
   import adc_regs_pkg::*;
#(
   parameter int NUM_CH             = 4,
   parameter int DATA_W             = 12,
   parameter int C_S_AXI_ADDR_WIDTH = 7
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   input  logic [NUM_CH*DATA_W-1:0]      ch_data,
   input  logic [NUM_CH-1:0]             ch_valid
`ifdef ADC_REGS_IRQ_EN
   ,
   output logic                          irq
`endif
);

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("adc_axil_regs_mc: NUM_CH out of range");
   end

   localparam logic [7:0] INFO_NCH = 8'(NUM_CH);
   localparam logic [7:0] INFO_DW  = 8'(DATA_W);

   logic                          wr_en, rd_en, wr_err, rd_err;
   logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [31:0]                   wr_data, rd_data, wa, ra, wmask;
   logic [3:0]                    wr_strb;
   logic [NUM_CH-1:0]             ctrl, new_flag, ovr, irq_en_rd;
   logic [NUM_CH-1:0]             cap, rd_hit, wr_hit, rd_clr, w1c, ctrl_next;
   logic [NUM_CH:0][31:0]         data_acc;

   adc_axil_if #(.ADDR_W(C_S_AXI_ADDR_WIDTH)) u_if (
      .clk     (S_AXI_ACLK),    .rst_n   (S_AXI_ARESETN),
      .awaddr  (S_AXI_AWADDR),  .awvalid (S_AXI_AWVALID), .awready (S_AXI_AWREADY),
      .wdata   (S_AXI_WDATA),   .wstrb   (S_AXI_WSTRB),   .wvalid  (S_AXI_WVALID),
      .wready  (S_AXI_WREADY),  .bresp   (S_AXI_BRESP),   .bvalid  (S_AXI_BVALID),
      .bready  (S_AXI_BREADY),  .araddr  (S_AXI_ARADDR),  .arvalid (S_AXI_ARVALID),
      .arready (S_AXI_ARREADY), .rdata   (S_AXI_RDATA),   .rresp   (S_AXI_RRESP),
      .rvalid  (S_AXI_RVALID),  .rready  (S_AXI_RREADY),
      .wr_en   (wr_en),   .wr_addr (wr_addr), .wr_data (wr_data), .wr_strb (wr_strb),
      .wr_err  (wr_err),  .rd_en   (rd_en),   .rd_addr (rd_addr), .rd_data (rd_data),
      .rd_err  (rd_err)
   );

   assign wa    = 32'(wr_addr);
   assign ra    = 32'(rd_addr);
   assign wmask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

   assign data_acc[0] = 32'd0;
   for (genvar g = 0; g < NUM_CH; g++) begin : ch_g
      logic [DATA_W-1:0] sample;
      assign rd_hit[g] = (ra == data_addr(g));
      assign wr_hit[g] = (wa == data_addr(g));
      assign data_acc[g+1] = data_acc[g] | (rd_hit[g] ? 32'(sample) : 32'd0);
      // Sample register for this channel; only enabled strobes load it.
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
         if (!S_AXI_ARESETN) begin
            sample <= '0;
         end else if (cap[g]) begin
            sample <= ch_data[g*DATA_W +: DATA_W];
         end else begin
            sample <= sample;
         end
      end
   end

   // A capture on the same edge as a clearing read or W1C keeps its flag set.
   assign cap       = ch_valid & ctrl;
   assign rd_clr    = rd_hit & {NUM_CH{rd_en}};
   assign w1c       = (wr_en && wa == ADDR_STATUS) ? (wr_data[STATUS_OVR_LSB +: NUM_CH] & wmask[STATUS_OVR_LSB +: NUM_CH]) : '0;
   assign ctrl_next = (wr_en && wa == ADDR_CTRL) ? ((ctrl & ~wmask[NUM_CH-1:0]) | (wr_data[NUM_CH-1:0] & wmask[NUM_CH-1:0])) : ctrl;
   assign wr_err    = ~((wa == ADDR_CTRL) | (wa == ADDR_STATUS) | (wa == ADDR_INFO) | (wa == ADDR_IRQ_EN) | (|wr_hit));

   // Control and status flag registers.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ctrl     <= '0;
         new_flag <= '0;
         ovr      <= '0;
      end else begin
         ctrl     <= ctrl_next;
         new_flag <= cap | (new_flag & ~rd_clr);
         ovr      <= (cap & new_flag) | (ovr & ~w1c);
      end
   end

`ifdef ADC_REGS_IRQ_EN
   logic [NUM_CH-1:0] irq_en;
   assign irq_en_rd = irq_en;
   // Interrupt enable register and registered interrupt level.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         irq_en <= '0;
         irq    <= 1'b0;
      end else begin
         irq_en <= (wr_en && wa == ADDR_IRQ_EN) ? ((irq_en & ~wmask[NUM_CH-1:0]) | (wr_data[NUM_CH-1:0] & wmask[NUM_CH-1:0])) : irq_en;
         irq    <= (|(new_flag & irq_en)) | (|ovr);
      end
   end
`else
   assign irq_en_rd = '0;
`endif

   // Read mux; anything not decoded reads zero with an error response.
   always_comb begin
      rd_data = 32'd0;
      rd_err  = 1'b0;
      case (ra)
         ADDR_CTRL:   rd_data = 32'(ctrl);
         ADDR_STATUS: rd_data = (32'(ovr) << STATUS_OVR_LSB) | (32'(new_flag) << STATUS_NEW_LSB);
         ADDR_INFO:   rd_data = {16'd0, INFO_DW, INFO_NCH};
         ADDR_IRQ_EN: rd_data = 32'(irq_en_rd);
         default: begin
            rd_data = data_acc[NUM_CH];
            rd_err  = ~(|rd_hit);
         end
      endcase
   end

   logic unused;
   assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, wr_data, wmask};

endmodule

// File: tb/tb_adc_axil_regs_mc.sv
// Directed self-checking bench for adc_axil_regs_mc; the irq scenario is
// compiled in only when ADC_REGS_IRQ_EN is defined.
module tb_adc_axil_regs_mc;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 12;
   localparam int AW     = 7;
   localparam int LIMIT  = 50;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [AW-1:0]            awaddr, araddr;
   logic [2:0]               awprot, arprot;
   logic                     awvalid, awready, wvalid, wready, bvalid, bready;
   logic                     arvalid, arready, rvalid, rready;
   logic [31:0]              wdata, rdata;
   logic [3:0]               wstrb;
   logic [1:0]               bresp, rresp;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_valid;
`ifdef ADC_REGS_IRQ_EN
   logic                     irq;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adc_axil_regs_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .C_S_AXI_ADDR_WIDTH(AW)) dut (
      .S_AXI_ACLK    (clk),     .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),  .S_AXI_AWPROT  (awprot),  .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready), .S_AXI_WDATA   (wdata),   .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),  .S_AXI_WREADY  (wready),  .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),  .S_AXI_BREADY  (bready),  .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),  .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),   .S_AXI_RRESP   (rresp),   .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),  .ch_data       (ch_data), .ch_valid      (ch_valid)
`ifdef ADC_REGS_IRQ_EN
      , .irq (irq)
`endif
   );

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while (awready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      while (bvalid !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      checks++;
      if (n >= LIMIT) begin failures++; $display("FAIL wr_timeout addr=%h got=no_response exp=response", a); end
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      while (rvalid !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      checks++;
      if (n >= LIMIT) begin failures++; $display("FAIL rd_timeout addr=%h got=no_response exp=response", a); end
      d = rdata; resp = rresp;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic pulse_ch(input int ch, input logic [DATA_W-1:0] v);
      @(negedge clk);
      ch_data[ch*DATA_W +: DATA_W] = v;
      ch_valid = '0;
      ch_valid[ch] = 1'b1;
      @(negedge clk);
      ch_valid = '0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r;
      awaddr = '0; araddr = '0; awprot = 3'b000; arprot = 3'b000; wdata = 32'd0; wstrb = 4'h0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      ch_data = '0; ch_valid = '0; rst_n = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== 41'd0) begin
         failures++; $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%b/%b/%h exp=all_zero",
                              awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata);
      end
`ifdef ADC_REGS_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
      @(negedge clk); rst_n = 1'b1;
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%h/%b exp=00000000/00", d, r); end
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin failures++; $display("FAIL reset_status got=%h/%b exp=00000000/00", d, r); end
   endtask

   task automatic test_ctrl_info();
      logic [31:0] d; logic [1:0] r;
      axi_write(7'h00, 32'h0000000F, 4'hF, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL ctrl_wr_resp got=%b exp=00", r); end
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h0000000F || r !== 2'b00) begin failures++; $display("FAIL ctrl_rd got=%h/%b exp=0000000f/00", d, r); end
      axi_read(7'h08, d, r);
      checks++;
      if (d !== 32'h00000C04 || r !== 2'b00) begin failures++; $display("FAIL info_rd got=%h/%b exp=00000c04/00", d, r); end
      axi_write(7'h00, 32'h00000000, 4'b1110, r);
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h0000000F) begin failures++; $display("FAIL ctrl_strb_off got=%h exp=0000000f", d); end
      axi_write(7'h00, 32'hFFFFFFF5, 4'b0001, r);
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h00000005) begin failures++; $display("FAIL ctrl_strb_mask got=%h exp=00000005", d); end
   endtask

   task automatic test_capture();
      logic [31:0] d; logic [1:0] r;
      axi_write(7'h00, 32'h0000000F, 4'hF, r);
      pulse_ch(2, 12'hABC);
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00000004) begin failures++; $display("FAIL cap_status got=%h exp=00000004", d); end
      axi_read(7'h18, d, r);
      checks++;
      if (d !== 32'h00000ABC || r !== 2'b00) begin failures++; $display("FAIL cap_data2 got=%h/%b exp=00000abc/00", d, r); end
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00000000) begin failures++; $display("FAIL cap_new_clear got=%h exp=00000000", d); end
   endtask

   task automatic test_overrun();
      logic [31:0] d; logic [1:0] r;
      pulse_ch(1, 12'h111);
      pulse_ch(1, 12'h222);
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00020002) begin failures++; $display("FAIL ovr_status got=%h exp=00020002", d); end
      axi_read(7'h14, d, r);
      checks++;
      if (d !== 32'h00000222) begin failures++; $display("FAIL ovr_data1 got=%h exp=00000222", d); end
      axi_write(7'h04, 32'h00020000, 4'hF, r);
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00000000) begin failures++; $display("FAIL ovr_w1c got=%h exp=00000000", d); end
   endtask

   task automatic test_disabled_unmapped();
      logic [31:0] d; logic [1:0] r;
      axi_write(7'h00, 32'h00000000, 4'hF, r);
      pulse_ch(0, 12'h5A5);
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00000000) begin failures++; $display("FAIL dis_status got=%h exp=00000000", d); end
      axi_read(7'h10, d, r);
      checks++;
      if (d !== 32'h00000000 || r !== 2'b00) begin failures++; $display("FAIL dis_data0 got=%h/%b exp=00000000/00", d, r); end
      axi_read(7'h40, d, r);
      checks++;
      if (d !== 32'h00000000 || r !== 2'b10) begin failures++; $display("FAIL unmapped_rd got=%h/%b exp=00000000/10", d, r); end
      axi_write(7'h40, 32'h12345678, 4'hF, r);
      checks++;
      if (r !== 2'b10) begin failures++; $display("FAIL unmapped_wr got=%b exp=10", r); end
      axi_write(7'h02, 32'h0000000F, 4'hF, r);
      checks++;
      if (r !== 2'b10) begin failures++; $display("FAIL unaligned_wr got=%b exp=10", r); end
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h00000000) begin failures++; $display("FAIL unaligned_no_effect got=%h exp=00000000", d); end
      axi_read(7'h02, d, r);
      checks++;
      if (d !== 32'h00000000 || r !== 2'b10) begin failures++; $display("FAIL unaligned_rd got=%h/%b exp=00000000/10", d, r); end
      axi_write(7'h0C, 32'h0000000F, 4'hF, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL irqen_wr_resp got=%b exp=00", r); end
      axi_read(7'h0C, d, r);
      checks++;
`ifdef ADC_REGS_IRQ_EN
      if (d !== 32'h0000000F) begin failures++; $display("FAIL irqen_rd got=%h exp=0000000f", d); end
`else
      if (d !== 32'h00000000) begin failures++; $display("FAIL irqen_rd got=%h exp=00000000", d); end
`endif
      axi_write(7'h0C, 32'h00000000, 4'hF, r);
   endtask

   task automatic test_same_cycle();
      logic [31:0] d; logic [1:0] r;
      int n;
      axi_write(7'h00, 32'h0000000F, 4'hF, r);
      pulse_ch(3, 12'h123);
      @(negedge clk);
      araddr = 7'h1C; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      ch_data[3*DATA_W +: DATA_W] = 12'h456;
      ch_valid[3] = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0; ch_valid = '0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h00000123) begin
         failures++; $display("FAIL same_cycle_old got=%b/%h exp=1/00000123", rvalid, rdata);
      end
      @(posedge clk); #1;
      rready = 1'b0;
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00080008) begin failures++; $display("FAIL same_cycle_status got=%h exp=00080008", d); end
      axi_read(7'h1C, d, r);
      checks++;
      if (d !== 32'h00000456) begin failures++; $display("FAIL same_cycle_new got=%h exp=00000456", d); end
      axi_write(7'h04, 32'h00080000, 4'hF, r);
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00000000) begin failures++; $display("FAIL same_cycle_clear got=%h exp=00000000", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [1:0] r;
      int n;
      @(negedge clk);
      awaddr = 7'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      while (awready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      wdata = 32'h7;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0) begin
            failures++; $display("FAIL b_hold cyc=%0d got=%b/%b exp=1/0", i, bvalid, awready);
         end
      end
      bready = 1'b1;
      n = 0;
      while (awready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || n >= LIMIT) begin
         failures++; $display("FAIL b_queued got=%b/%b exp=1/00", bvalid, bresp);
      end
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      araddr = 7'h08; arvalid = 1'b1; rready = 1'b0;
      n = 0;
      while (arready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      araddr = 7'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'h00000C04) begin
            failures++; $display("FAIL r_hold cyc=%0d got=%b/%b/%h exp=1/0/00000c04", i, rvalid, arready, rdata);
         end
      end
      rready = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h00000007 || n >= LIMIT) begin
         failures++; $display("FAIL r_queued got=%b/%h exp=1/00000007", rvalid, rdata);
      end
      @(posedge clk); #1;
      rready = 1'b0;
      axi_read(7'h04, d, r);
      checks++;
      if (d !== 32'h00000000) begin failures++; $display("FAIL b2b_status got=%h exp=00000000", d); end
   endtask

`ifdef ADC_REGS_IRQ_EN
   task automatic test_irq();
      logic [31:0] d; logic [1:0] r;
      axi_write(7'h0C, 32'h00000001, 4'hF, r);
      axi_write(7'h00, 32'h0000000F, 4'hF, r);
      pulse_ch(0, 12'h321);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
      axi_read(7'h10, d, r);
      checks++;
      if (d !== 32'h00000321) begin failures++; $display("FAIL irq_data0 got=%h exp=00000321", d); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
   endtask
`endif

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r;
      int n;
      @(negedge clk);
      awaddr = 7'h00; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      while (awready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} !== 41'd0) begin
         failures++; $display("FAIL mid_reset_outputs got=%b/%b/%b/%b/%b/%b/%b/%h exp=all_zero",
                              awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata);
      end
`ifdef ADC_REGS_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
`endif
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
         failures++; $display("FAIL stale_resp got=%b/%b exp=0/0", bvalid, rvalid);
      end
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h00000000 || r !== 2'b00) begin failures++; $display("FAIL mid_ctrl_reset got=%h/%b exp=00000000/00", d, r); end
      axi_write(7'h00, 32'h00000005, 4'hF, r);
      axi_read(7'h00, d, r);
      checks++;
      if (d !== 32'h00000005 || r !== 2'b00) begin failures++; $display("FAIL mid_fresh_txn got=%h/%b exp=00000005/00", d, r); end
   endtask

   initial begin
      test_reset();
      test_ctrl_info();
      test_capture();
      test_overrun();
      test_disabled_unmapped();
      test_same_cycle();
      test_back_to_back();
`ifdef ADC_REGS_IRQ_EN
      test_irq();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
